// File: rtl/plru_state_array.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// plru_state_array
//
// Purpose
//   Tree pseudo-LRU replacement state for an NWAY-way, NSET-set L1 data cache.
//   Each set holds NWAY-1 tree bits. Heap node k (1..NWAY-1) lives at bit k-1,
//   the root is k=1 and the children of k are 2k and 2k+1. A node bit of 0 means
//   the victim lies on the low-way side, 1 means the high-way side.
//   Two update ports (hit and refill) "touch" a way so that every node on its
//   path points away from it. A victim lookup returns, one cycle later, either
//   the lowest invalid way or the way found by walking the tree.
//
// Configuration macro
//   PLRU_WR_BYPASS_EN  defined:   a lookup walks the state that this cycle's
//                                 updates will produce (clear_all, then hit,
//                                 then refill).
//                      undefined: a lookup walks the stored state, which may be
//                                 one cycle stale relative to a same-cycle
//                                 update of the same set.
//
// Ports
//   clk            clock
//   rst            synchronous active-high reset: all state and the response
//                  register go to zero; a pending response is dropped
//   hit_upd_vld    hit touched a way         (hit_upd_set, hit_upd_way)
//   rfl_upd_vld    refill wrote a way        (rfl_upd_set, rfl_upd_way)
//   vic_req_vld    victim lookup request     (vic_req_set, vic_req_vmask)
//   vic_rsp_vld    response valid, one cycle after the request
//   vic_rsp_way    chosen victim way
//   vic_rsp_inv    1 when the victim was chosen because it was invalid
//   clear_all      zero every set's state at the next edge; beats both
//                  update ports in the same cycle
// -----------------------------------------------------------------------------
module plru_state_array #(
    parameter int NSET  = 64,
    parameter int NWAY  = 8,
    parameter int SET_W = $clog2(NSET),
    parameter int WAY_W = $clog2(NWAY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit_upd_vld,
    input  logic [SET_W-1:0] hit_upd_set,
    input  logic [WAY_W-1:0] hit_upd_way,
    input  logic             rfl_upd_vld,
    input  logic [SET_W-1:0] rfl_upd_set,
    input  logic [WAY_W-1:0] rfl_upd_way,
    input  logic             vic_req_vld,
    input  logic [SET_W-1:0] vic_req_set,
    input  logic [NWAY-1:0]  vic_req_vmask,
    output logic             vic_rsp_vld,
    output logic [WAY_W-1:0] vic_rsp_way,
    output logic             vic_rsp_inv,
    input  logic             clear_all
);

    localparam int NODE_W = NWAY - 1;

    // -------------------------------------------------------------------------
    // Tree helpers
    // -------------------------------------------------------------------------

    // Make every node on the path of 'way' point away from it. Bits are
    // written, not toggled, so touching the same way twice is idempotent.
    function automatic logic [NODE_W-1:0] f_touch(
        input logic [NODE_W-1:0] tree,
        input logic [WAY_W-1:0]  way
    );
        logic [NODE_W-1:0] res;
        int                k;
        res = tree;
        k   = 1;
        for (int l = 0; l < WAY_W; l++) begin
            res[k-1] = ~way[WAY_W-1-l];
            if (way[WAY_W-1-l]) begin
                k = 2 * k + 1;
            end else begin
                k = 2 * k;
            end
        end
        return res;
    endfunction

    // Follow the node bits from the root down to a leaf; the leaf heap index
    // minus NWAY is the way number.
    function automatic logic [WAY_W-1:0] f_walk(
        input logic [NODE_W-1:0] tree
    );
        int k;
        k = 1;
        for (int l = 0; l < WAY_W; l++) begin
            if (tree[k-1]) begin
                k = 2 * k + 1;
            end else begin
                k = 2 * k;
            end
        end
        return WAY_W'(k - NWAY);
    endfunction

    // Lowest-indexed way whose valid bit is clear. Scanning from the top down
    // lets the lowest index overwrite any higher hit.
    function automatic logic [WAY_W-1:0] f_first_zero(
        input logic [NWAY-1:0] vmask
    );
        logic [WAY_W-1:0] res;
        res = '0;
        for (int i = NWAY - 1; i >= 0; i--) begin
            if (!vmask[i]) begin
                res = WAY_W'(i);
            end
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Per-set state. Kept in flops rather than RAM: clear_all must zero every
    // set in one edge, and two sets can be written in the same cycle.
    // -------------------------------------------------------------------------
    logic [NODE_W-1:0] w_lkp_src [NSET];

    generate
        for (genvar gi = 0; gi < NSET; gi++) begin : g_set
            logic [NODE_W-1:0] r_tree;
            logic [NODE_W-1:0] w_tree_next;
            logic              w_hit_here;
            logic              w_rfl_here;

            assign w_hit_here = hit_upd_vld && (hit_upd_set == SET_W'(gi));
            assign w_rfl_here = rfl_upd_vld && (rfl_upd_set == SET_W'(gi));

            // Hit is applied first and refill on top of it, so refill wins on
            // any node both paths share.
            always_comb begin
                w_tree_next = r_tree;
                if (clear_all) begin
                    w_tree_next = '0;
                end else begin
                    if (w_hit_here) begin
                        w_tree_next = f_touch(w_tree_next, hit_upd_way);
                    end
                    if (w_rfl_here) begin
                        w_tree_next = f_touch(w_tree_next, rfl_upd_way);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_tree <= '0;
                end else begin
                    r_tree <= w_tree_next;
                end
            end

`ifdef PLRU_WR_BYPASS_EN
            assign w_lkp_src[gi] = w_tree_next;
`else
            assign w_lkp_src[gi] = r_tree;
`endif
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Victim selection (combinational in the request cycle)
    // -------------------------------------------------------------------------
    logic [NODE_W-1:0] w_lkp_tree;
    logic              w_any_inv;
    logic [WAY_W-1:0]  w_inv_way;
    logic [WAY_W-1:0]  w_plru_way;
    logic [WAY_W-1:0]  w_vic_way;

    assign w_lkp_tree = w_lkp_src[vic_req_set];
    assign w_any_inv  = ~&vic_req_vmask;
    assign w_inv_way  = f_first_zero(vic_req_vmask);
    assign w_plru_way = f_walk(w_lkp_tree);
    assign w_vic_way  = w_any_inv ? w_inv_way : w_plru_way;

    // -------------------------------------------------------------------------
    // Registered response. Way/inv hold their last value when no request is
    // made; only vic_rsp_vld qualifies them.
    // -------------------------------------------------------------------------
    logic             r_rsp_vld;
    logic [WAY_W-1:0] r_rsp_way;
    logic             r_rsp_inv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_vld <= 1'b0;
            r_rsp_way <= '0;
            r_rsp_inv <= 1'b0;
        end else begin
            r_rsp_vld <= vic_req_vld;
            if (vic_req_vld) begin
                r_rsp_way <= w_vic_way;
                r_rsp_inv <= w_any_inv;
            end
        end
    end

    assign vic_rsp_vld = r_rsp_vld;
    assign vic_rsp_way = r_rsp_way;
    assign vic_rsp_inv = r_rsp_inv;

endmodule

// File: tb/tb_plru_state_array.sv
`timescale 1ns/1ps
module tb_plru_state_array;

    localparam int NSET  = 64;
    localparam int NWAY  = 8;
    localparam int SET_W = $clog2(NSET);
    localparam int WAY_W = $clog2(NWAY);

    logic             clk = 1'b0;
    logic             rst;
    logic             hit_upd_vld;
    logic [SET_W-1:0] hit_upd_set;
    logic [WAY_W-1:0] hit_upd_way;
    logic             rfl_upd_vld;
    logic [SET_W-1:0] rfl_upd_set;
    logic [WAY_W-1:0] rfl_upd_way;
    logic             vic_req_vld;
    logic [SET_W-1:0] vic_req_set;
    logic [NWAY-1:0]  vic_req_vmask;
    logic             vic_rsp_vld;
    logic [WAY_W-1:0] vic_rsp_way;
    logic             vic_rsp_inv;
    logic             clear_all;

    plru_state_array #(.NSET(NSET), .NWAY(NWAY)) dut (
        .clk           (clk),
        .rst           (rst),
        .hit_upd_vld   (hit_upd_vld),
        .hit_upd_set   (hit_upd_set),
        .hit_upd_way   (hit_upd_way),
        .rfl_upd_vld   (rfl_upd_vld),
        .rfl_upd_set   (rfl_upd_set),
        .rfl_upd_way   (rfl_upd_way),
        .vic_req_vld   (vic_req_vld),
        .vic_req_set   (vic_req_set),
        .vic_req_vmask (vic_req_vmask),
        .vic_rsp_vld   (vic_rsp_vld),
        .vic_rsp_way   (vic_rsp_way),
        .vic_rsp_inv   (vic_rsp_inv),
        .clear_all     (clear_all)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected response for the request issued in the most recent step().
    logic             exp_vld;
    logic [WAY_W-1:0] exp_way;
    logic             exp_inv;

    // Reference model: one bit per heap node of each set's tree, index 1..NWAY-1.
    bit m_node [NSET][NWAY];

    function automatic void m_clear();
        for (int s = 0; s < NSET; s++)
            for (int n = 0; n < NWAY; n++)
                m_node[s][n] = 1'b0;
    endfunction

    // The leaf of way w is heap index NWAY+w; its ancestor at level l is that
    // index shifted right by (WAY_W-l), and the direction taken below that
    // ancestor is the next lower bit. The node must point the other way.
    function automatic void m_touch(input int s, input int w);
        for (int l = 0; l < WAY_W; l++) begin
            int node;
            int dir;
            node = (NWAY + w) >> (WAY_W - l);
            dir  = ((NWAY + w) >> (WAY_W - l - 1)) & 1;
            m_node[s][node] = (dir == 0);
        end
    endfunction

    function automatic void m_victim(input int s, input logic [NWAY-1:0] vm,
                                     output int way, output bit inv);
        int n;
        way = -1;
        for (int i = 0; i < NWAY; i++)
            if (way < 0 && vm[i] == 1'b0) way = i;
        if (way >= 0) begin
            inv = 1'b1;
        end else begin
            inv = 1'b0;
            n = 1;
            while (n < NWAY) n = 2 * n + int'(m_node[s][n]);
            way = n - NWAY;
        end
    endfunction

    task automatic idle_inputs();
        rst = 0; clear_all = 0;
        hit_upd_vld = 0; hit_upd_set = '0; hit_upd_way = '0;
        rfl_upd_vld = 0; rfl_upd_set = '0; rfl_upd_way = '0;
        vic_req_vld = 0; vic_req_set = '0; vic_req_vmask = '1;
    endtask

    // Runs one clock with the currently driven inputs, keeps the model in
    // step, computes the expected response and returns #1 after the edge.
    task automatic step();
        int w;
        bit inv;
        exp_vld = vic_req_vld && !rst;
`ifndef PLRU_WR_BYPASS_EN
        if (vic_req_vld) begin
            m_victim(int'(vic_req_set), vic_req_vmask, w, inv);
            exp_way = w[WAY_W-1:0]; exp_inv = inv;
        end
`endif
        if (rst || clear_all) begin
            m_clear();
        end else begin
            if (hit_upd_vld) m_touch(int'(hit_upd_set), int'(hit_upd_way));
            if (rfl_upd_vld) m_touch(int'(rfl_upd_set), int'(rfl_upd_way));
        end
`ifdef PLRU_WR_BYPASS_EN
        if (vic_req_vld) begin
            m_victim(int'(vic_req_set), vic_req_vmask, w, inv);
            exp_way = w[WAY_W-1:0]; exp_inv = inv;
        end
`endif
        if (rst) begin
            exp_way = '0; exp_inv = 1'b0;
        end
        if (vic_req_vld)
            $display("txn t=%0t req set=%0d vmask=%h hit=%0b/%0d/%0d rfl=%0b/%0d/%0d clr=%0b rst=%0b",
                     $time, vic_req_set, vic_req_vmask, hit_upd_vld, hit_upd_set, hit_upd_way,
                     rfl_upd_vld, rfl_upd_set, rfl_upd_way, clear_all, rst);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst = 1; vic_req_vld = 1; vic_req_set = 6'd3;
        step();
        rst = 1;
        step();
        n_checks++;
        if (vic_rsp_vld !== 1'b0 || vic_rsp_way !== 3'd0 || vic_rsp_inv !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: vld=%0b way=%0d inv=%0b required 0/0/0", vic_rsp_vld, vic_rsp_way, vic_rsp_inv);
        end
        vic_req_vld = 1; vic_req_set = 6'd3; vic_req_vmask = 8'hFF;
        step();
        n_checks++;
        if (vic_rsp_vld !== 1'b1 || vic_rsp_way !== 3'd0 || vic_rsp_inv !== 1'b0) begin
            n_fail++;
            $display("FAIL first_lookup: vld=%0b way=%0d inv=%0b required 1/0/0", vic_rsp_vld, vic_rsp_way, vic_rsp_inv);
        end
    endtask

    task automatic test_plru_walk();
        hit_upd_vld = 1; hit_upd_set = 6'd3; hit_upd_way = 3'd0;
        step();
        n_checks++;
        if (vic_rsp_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_rsp: vld=%0b required 0", vic_rsp_vld);
        end
        vic_req_vld = 1; vic_req_set = 6'd3;
        step();
        n_checks++;
        if (vic_rsp_vld !== 1'b1 || vic_rsp_way !== 3'd4 || vic_rsp_inv !== 1'b0) begin
            n_fail++;
            $display("FAIL walk_after_hit0: vld=%0b way=%0d inv=%0b required 1/4/0", vic_rsp_vld, vic_rsp_way, vic_rsp_inv);
        end
        hit_upd_vld = 1; hit_upd_set = 6'd3; hit_upd_way = 3'd4;
        step();
        vic_req_vld = 1; vic_req_set = 6'd3;
        step();
        n_checks++;
        if (vic_rsp_vld !== 1'b1 || vic_rsp_way !== 3'd2 || vic_rsp_inv !== 1'b0) begin
            n_fail++;
            $display("FAIL walk_after_hit4: vld=%0b way=%0d inv=%0b required 1/2/0", vic_rsp_vld, vic_rsp_way, vic_rsp_inv);
        end
    endtask

    task automatic test_invalid_priority();
        hit_upd_vld = 1; hit_upd_set = 6'd5; hit_upd_way = 3'd6;
        step();
        vic_req_vld = 1; vic_req_set = 6'd5; vic_req_vmask = 8'b1111_0111;
        step();
        n_checks++;
        if (vic_rsp_vld !== 1'b1 || vic_rsp_way !== 3'd3 || vic_rsp_inv !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_way3: vld=%0b way=%0d inv=%0b required 1/3/1", vic_rsp_vld, vic_rsp_way, vic_rsp_inv);
        end
        vic_req_vld = 1; vic_req_set = 6'd5; vic_req_vmask = 8'h00;
        step();
        n_checks++;
        if (vic_rsp_vld !== 1'b1 || vic_rsp_way !== 3'd0 || vic_rsp_inv !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_all: vld=%0b way=%0d inv=%0b required 1/0/1", vic_rsp_vld, vic_rsp_way, vic_rsp_inv);
        end
    endtask

    task automatic test_dual_update();
        hit_upd_vld = 1; hit_upd_set = 6'd7; hit_upd_way = 3'd0;
        rfl_upd_vld = 1; rfl_upd_set = 6'd7; rfl_upd_way = 3'd7;
        step();
        vic_req_vld = 1; vic_req_set = 6'd7;
        step();
        n_checks++;
        if (vic_rsp_vld !== 1'b1 || vic_rsp_way !== 3'd2 || vic_rsp_inv !== 1'b0) begin
            n_fail++;
            $display("FAIL dual_same_set: vld=%0b way=%0d inv=%0b required 1/2/0", vic_rsp_vld, vic_rsp_way, vic_rsp_inv);
        end
        // Different sets in one cycle, then same set and same way.
        hit_upd_vld = 1; hit_upd_set = 6'd20; hit_upd_way = 3'd1;
        rfl_upd_vld = 1; rfl_upd_set = 6'd21; rfl_upd_way = 3'd6;
        step();
        hit_upd_vld = 1; hit_upd_set = 6'd22; hit_upd_way = 3'd5;
        rfl_upd_vld = 1; rfl_upd_set = 6'd22; rfl_upd_way = 3'd5;
        for (int s = 20; s < 23; s++) begin
            vic_req_vld = 1; vic_req_set = SET_W'(s);
            step();
            n_checks++;
            if (vic_rsp_vld !== exp_vld || vic_rsp_way !== exp_way || vic_rsp_inv !== exp_inv) begin
                n_fail++;
                $display("FAIL dual_set%0d: vld=%0b way=%0d inv=%0b required %0b/%0d/%0b",
                         s, vic_rsp_vld, vic_rsp_way, vic_rsp_inv, exp_vld, exp_way, exp_inv);
            end
        end
    endtask

    task automatic test_same_cycle_lookup();
        hit_upd_vld = 1; hit_upd_set = 6'd9; hit_upd_way = 3'd5;
        vic_req_vld = 1; vic_req_set = 6'd9;
        step();
        n_checks++;
        if (vic_rsp_vld !== 1'b1 || vic_rsp_way !== 3'd0 || vic_rsp_inv !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_same_set9: vld=%0b way=%0d inv=%0b required 1/0/0", vic_rsp_vld, vic_rsp_way, vic_rsp_inv);
        end
        // Fresh set 11: hit way 0 with a same-cycle lookup.
        hit_upd_vld = 1; hit_upd_set = 6'd11; hit_upd_way = 3'd0;
        vic_req_vld = 1; vic_req_set = 6'd11;
        step();
        n_checks++;
`ifdef PLRU_WR_BYPASS_EN
        if (vic_rsp_vld !== 1'b1 || vic_rsp_way !== 3'd4) begin
            n_fail++;
            $display("FAIL rw_bypass: vld=%0b way=%0d required 1/4", vic_rsp_vld, vic_rsp_way);
        end
`else
        if (vic_rsp_vld !== 1'b1 || vic_rsp_way !== 3'd0) begin
            n_fail++;
            $display("FAIL rw_stale: vld=%0b way=%0d required 1/0", vic_rsp_vld, vic_rsp_way);
        end
`endif
        // Set 9 again: hit way 0 with a lookup, on top of the earlier hit.
        hit_upd_vld = 1; hit_upd_set = 6'd9; hit_upd_way = 3'd0;
        vic_req_vld = 1; vic_req_set = 6'd9;
        step();
        n_checks++;
        if (vic_rsp_vld !== exp_vld || vic_rsp_way !== exp_way || vic_rsp_inv !== exp_inv) begin
            n_fail++;
            $display("FAIL rw_set9_second: vld=%0b way=%0d inv=%0b required %0b/%0d/%0b",
                     vic_rsp_vld, vic_rsp_way, vic_rsp_inv, exp_vld, exp_way, exp_inv);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            hit_upd_vld = ($urandom_range(0, 1) == 1);
            hit_upd_set = ($urandom_range(0, 1) == 1) ? SET_W'($urandom_range(0, 3)) : SET_W'($urandom);
            hit_upd_way = WAY_W'($urandom);
            rfl_upd_vld = ($urandom_range(0, 2) == 0);
            rfl_upd_set = ($urandom_range(0, 1) == 1) ? SET_W'($urandom_range(0, 3)) : SET_W'($urandom);
            rfl_upd_way = WAY_W'($urandom);
            vic_req_vld = ($urandom_range(0, 3) != 0);
            vic_req_set = ($urandom_range(0, 1) == 1) ? SET_W'($urandom_range(0, 3)) : SET_W'($urandom);
            vic_req_vmask = ($urandom_range(0, 3) == 0) ? NWAY'($urandom) : '1;
            clear_all = ($urandom_range(0, 59) == 0);
            step();
            n_checks++;
            if (vic_rsp_vld !== exp_vld || (exp_vld && (vic_rsp_way !== exp_way || vic_rsp_inv !== exp_inv))) begin
                n_fail++;
                $display("FAIL random_c%0d: vld=%0b way=%0d inv=%0b required %0b/%0d/%0b",
                         c, vic_rsp_vld, vic_rsp_way, vic_rsp_inv, exp_vld, exp_way, exp_inv);
            end
        end
    endtask

    task automatic test_clear_all();
        for (int s = 0; s < NSET; s++) begin
            hit_upd_vld = 1; hit_upd_set = SET_W'(s); hit_upd_way = WAY_W'($urandom_range(0, 3));
            rfl_upd_vld = 1; rfl_upd_set = SET_W'(NSET - 1 - s); rfl_upd_way = WAY_W'($urandom);
            step();
        end
        clear_all = 1;
        hit_upd_vld = 1; hit_upd_set = 6'd10; hit_upd_way = 3'd3;
        vic_req_vld = 1; vic_req_set = 6'd10;
        step();
        n_checks++;
        if (vic_rsp_vld !== exp_vld || vic_rsp_way !== exp_way || vic_rsp_inv !== exp_inv) begin
            n_fail++;
            $display("FAIL clear_same_cycle: vld=%0b way=%0d inv=%0b required %0b/%0d/%0b",
                     vic_rsp_vld, vic_rsp_way, vic_rsp_inv, exp_vld, exp_way, exp_inv);
        end
        for (int s = 0; s < NSET; s++) begin
            vic_req_vld = 1; vic_req_set = SET_W'(s);
            step();
            n_checks++;
            if (vic_rsp_vld !== 1'b1 || vic_rsp_way !== 3'd0 || vic_rsp_inv !== 1'b0) begin
                n_fail++;
                $display("FAIL cleared_set%0d: vld=%0b way=%0d inv=%0b required 1/0/0",
                         s, vic_rsp_vld, vic_rsp_way, vic_rsp_inv);
            end
        end
    endtask

    task automatic test_reset_mid_lookup();
        hit_upd_vld = 1; hit_upd_set = 6'd3; hit_upd_way = 3'd0;
        step();
        rst = 1; vic_req_vld = 1; vic_req_set = 6'd3;
        step();
        n_checks++;
        if (vic_rsp_vld !== 1'b0 || vic_rsp_way !== 3'd0 || vic_rsp_inv !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drops_rsp: vld=%0b way=%0d inv=%0b required 0/0/0", vic_rsp_vld, vic_rsp_way, vic_rsp_inv);
        end
        vic_req_vld = 1; vic_req_set = 6'd3;
        step();
        n_checks++;
        if (vic_rsp_vld !== 1'b1 || vic_rsp_way !== 3'd0 || vic_rsp_inv !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_lookup: vld=%0b way=%0d inv=%0b required 1/0/0", vic_rsp_vld, vic_rsp_way, vic_rsp_inv);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        m_clear();
        exp_vld = 0; exp_way = '0; exp_inv = 0;
        #1;
        test_reset();
        test_plru_walk();
        test_invalid_priority();
        test_dual_update();
        test_same_cycle_lookup();
        test_random();
        test_clear_all();
        test_reset_mid_lookup();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
